// File: rtl/dcpu_prefetch.sv
// Instruction prefetch queue between the dcpu fetch stage and the 16-bit bus.
// Latency: a word acked on an empty queue is presented the cycle after i_ack (same cycle with bypass).
// Backpressure: stops requesting when the queue plus the outstanding word would exceed DEPTH.
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_flush, i_flush_addr       discard queue and restart fetch at the given byte address
//   i_rd                        core consumes the head word this cycle
//   o_valid, o_instr,
//   o_instr_addr                head word and its byte address
//   o_cyc, o_stb, o_addr, o_we  bus request (read only)
//   i_ack, i_dat                bus acknowledge and read data
//
// Optional feature: define DCPU_PREFETCH_BYPASS_EN to present an acked word on an
// empty queue combinationally in the same cycle as i_ack.

module dcpu_prefetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_flush,
    input  logic [AW-1:0] i_flush_addr,
    input  logic          i_rd,
    output logic          o_valid,
    output logic [15:0]   o_instr,
    output logic [AW-1:0] o_instr_addr,
    output logic          o_cyc,
    output logic [1:0]    o_stb,
    output logic [AW-1:0] o_addr,
    output logic          o_we,
    input  logic          i_ack,
    input  logic [15:0]   i_dat
);

    localparam int            IW      = $clog2(DEPTH);
    localparam logic [IW:0]   DEPTH_C = (IW+1)'(DEPTH);
    localparam logic [AW-1:0] STEP    = AW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] fetch_ptr;
    logic [IW:0]   count;
    logic [IW:0]   count_after;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [15:0]   dat_mem  [DEPTH];

    logic          ack_take;
    logic          push;
    logic          pop_fifo;
    logic [AW-1:0] flush_ptr;
    logic [AW-1:0] next_ptr;

    // Instruction addresses are halfword aligned; bit 0 of the flush target is dropped.
    assign flush_ptr = i_flush_addr & ~AW'(1);
    assign next_ptr  = fetch_ptr + STEP;

    // A word is accepted only for a live request; acks in IDLE/DRAIN or under flush are dropped.
    assign ack_take  = (state == REQ) && i_ack && !i_flush;

    // A flush wins over a simultaneous read.
    assign pop_fifo  = i_rd && (count != '0) && !i_flush;

    assign o_we      = 1'b0;

`ifdef DCPU_PREFETCH_BYPASS_EN
    logic byp;
    // Empty queue and a word arriving now: forward it straight to the core.
    assign byp          = ack_take && (count == '0);
    assign o_valid      = (count != '0) || byp;
    assign o_instr      = byp ? i_dat  : dat_mem[rd_idx];
    assign o_instr_addr = byp ? o_addr : addr_mem[rd_idx];
    // A bypassed word that the core takes immediately never enters the queue.
    assign push         = ack_take && !(byp && i_rd);
`else
    assign o_valid      = (count != '0);
    assign o_instr      = dat_mem[rd_idx];
    assign o_instr_addr = addr_mem[rd_idx];
    assign push         = ack_take;
`endif

    // Occupancy after this cycle's push/pop; decides whether another request may issue.
    always_comb begin
        count_after = count;
        if (push && !pop_fifo) begin
            count_after = count + 1'b1;
        end else if (!push && pop_fifo) begin
            count_after = count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_mem[wr_idx] <= o_addr;
            dat_mem[wr_idx]  <= i_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            o_cyc     <= 1'b0;
            o_stb     <= 2'b00;
            o_addr    <= '0;
            fetch_ptr <= '0;
            count     <= '0;
            rd_idx    <= '0;
            wr_idx    <= '0;
        end else begin
            if (i_flush) begin
                count  <= '0;
                rd_idx <= '0;
                wr_idx <= '0;
            end else begin
                count <= count_after;
                if (push) begin
                    wr_idx <= wr_idx + 1'b1;
                end
                if (pop_fifo) begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (i_flush) begin
                        fetch_ptr <= flush_ptr;
                    end else if (count < DEPTH_C) begin
                        state  <= REQ;
                        o_cyc  <= 1'b1;
                        o_stb  <= 2'b11;
                        o_addr <= fetch_ptr;
                    end
                end

                REQ: begin
                    if (i_flush) begin
                        fetch_ptr <= flush_ptr;
                        if (i_ack) begin
                            // Old request completed this cycle; restart immediately.
                            o_addr <= flush_ptr;
                        end else begin
                            // Bus cycle cannot be abandoned; wait out the stale word.
                            state <= DRAIN;
                        end
                    end else if (i_ack) begin
                        fetch_ptr <= next_ptr;
                        // count_after includes this word, so the next request always has room.
                        if (count_after < DEPTH_C) begin
                            o_addr <= next_ptr;
                        end else begin
                            state <= IDLE;
                            o_cyc <= 1'b0;
                            o_stb <= 2'b00;
                        end
                    end
                end

                DRAIN: begin
                    if (i_ack) begin
                        state <= REQ;
                        if (i_flush) begin
                            fetch_ptr <= flush_ptr;
                            o_addr    <= flush_ptr;
                        end else begin
                            o_addr <= fetch_ptr;
                        end
                    end else if (i_flush) begin
                        fetch_ptr <= flush_ptr;
                    end
                end

                default: begin
                    state <= IDLE;
                    o_cyc <= 1'b0;
                    o_stb <= 2'b00;
                end
            endcase
        end
    end

endmodule
